spill_splitter: RTL and testbench

SPILL_SPLITTER -- requirements
Module: spill_splitter

---
 rtl/spill_splitter_if.sv | 50 +++++
 rtl/spill_splitter.sv | 242 ++++++++++++++++++++++++
 tb/tb_spill_splitter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spill_splitter_if.sv
// Bus interfaces for spill_splitter: a single-ID AXI4 memory port (64-bit data, 32-bit address)
// and a simple valid-only register port with a one-cycle read return.
interface axi_bus_t;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic        wvalid;
   logic        wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        bvalid;
   logic        bready;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic        rlast;

   modport master (
      output awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, arsize, rready,
      input  awready, wready, bvalid, arready, rvalid, rdata, rlast
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, arsize, rready,
      output awready, wready, bvalid, arready, rvalid, rdata, rlast
   );
endinterface

interface reg_bus_t;
   logic        wvalid;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        arvalid;
   logic [7:0]  araddr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
   modport slave  (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
endinterface

// File: rtl/spill_splitter.sv
// Re-enqueues one spilled task slot as child tasks, then bumps the chunk's done count and,
// when every splitter of the chunk has finished, pushes the chunk back onto the free stack.
module spill_splitter #(
   parameter int TILE_ID                        = 0,
   parameter int CORE_ID                        = 3,
   parameter int TQ_WIDTH                       = 64,
   parameter int TASKS_PER_SPLITTER             = 8,
   parameter int LOG_TASK_WIDTH                 = 6,
   parameter int LOG_SPLITTER_CHUNK_WIDTH       = 9,
   parameter int LOG_SPLITTERS_PER_CHUNK        = 2,
   parameter int STACK_WIDTH                    = 16,
   parameter int LOG_SPLITTER_STACK_ENTRY_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   axi_bus_t.master            l1,
   reg_bus_t.slave             reg_bus,
   input  logic                splitter_valid,
   output logic                splitter_ready,
   input  logic [TQ_WIDTH-1:0] splitter_task,
   output logic                child_valid,
   input  logic                child_ready,
   output logic [TQ_WIDTH-1:0] child_task,
   output logic                stack_lock_out,
   input  logic                stack_lock_in
);

   localparam int SPLITTERS_PER_CHUNK = 1 << LOG_SPLITTERS_PER_CHUNK;

   localparam logic [4:0] IDLE = 5'd0, RD_REQ = 5'd1, RD_DATA = 5'd2, GRAB_LOCK = 5'd3,
                          HOLD_LOCK = 5'd4, RD_CNT = 5'd5, RD_CNT_WAIT = 5'd6, WR_CNT = 5'd7,
                          WR_CNT_WAIT = 5'd8, RD_PTR = 5'd9, RD_PTR_WAIT = 5'd10, WR_ENTRY = 5'd11,
                          WR_ENTRY_WAIT = 5'd12, WR_PTR = 5'd13, WR_PTR_WAIT = 5'd14,
                          RELEASE = 5'd15, DONE = 5'd16;

   localparam logic [7:0] REG_CORE_START      = 8'h00, REG_SPILL_BASE_TASKS = 8'h04,
                          REG_SPILL_BASE_STACK = 8'h08, REG_SPILL_BASE_SCRATCH = 8'h0C,
                          REG_SPILL_STACK_PTR  = 8'h10, REG_CORE_NUM_DEQ = 8'h14,
                          REG_CORE_NUM_ENQ     = 8'h18, REG_CORE_STATE = 8'h1C,
                          REG_CORE_NUM_FREES   = 8'h20, REG_TILE_INFO = 8'h24;

   logic [4:0]  r_state;
   logic        r_start;
   logic [31:0] r_base_tasks, r_base_stack, r_base_scratch, r_ptr_addr;
   logic [15:0] r_slot, r_chunk, r_cnt, r_ptr;
   logic [7:0]  r_beats;
   logic        r_lock;
   logic [31:0] r_num_splits, r_num_children, r_num_frees;
   logic        r_reg_rvalid;
   logic [31:0] r_reg_rdata;

   logic        w_split_hs, w_child_hs, w_aw_w_hs, w_last_beat, w_chunk_full;
   logic [16:0] w_cnt_inc;
   logic [15:0] w_ptr_dec;
   logic [31:0] w_task_addr, w_cnt_addr, w_entry_addr, w_reg_rdata;
   logic        w_unused;

   // Only locale[31:16] of the dispatched task is meaningful to this block.
   assign w_unused = ^splitter_task;

   assign w_split_hs   = splitter_valid & splitter_ready;
   assign w_child_hs   = child_valid & child_ready;
   assign w_aw_w_hs    = l1.awvalid & l1.awready & l1.wvalid & l1.wready;
   assign w_last_beat  = l1.rlast || (r_beats == 8'(TASKS_PER_SPLITTER - 1));
   assign w_cnt_inc    = {1'b0, r_cnt} + 17'd1;
   assign w_chunk_full = !(w_cnt_inc < 17'(SPLITTERS_PER_CHUNK));
   assign w_ptr_dec    = r_ptr - 16'd1;
   assign w_task_addr  = r_base_tasks + ({16'b0, r_slot} << LOG_SPLITTER_CHUNK_WIDTH);
   assign w_cnt_addr   = r_base_scratch + ({16'b0, r_chunk} << 1);
   assign w_entry_addr = r_base_stack + ({16'b0, w_ptr_dec} << (LOG_SPLITTER_STACK_ENTRY_WIDTH - 3));

   assign stack_lock_out  = r_lock;
   assign splitter_ready  = (r_state == IDLE) && r_start;
   assign child_valid     = (r_state == RD_DATA) && l1.rvalid;
   assign child_task      = l1.rdata[TQ_WIDTH-1:0];
   assign reg_bus.rvalid  = r_reg_rvalid;
   assign reg_bus.rdata   = r_reg_rdata;

   // AXI channel drive is a pure function of state; task beats pass straight through to child.
   always_comb begin
      l1.arvalid = 1'b0;
      l1.araddr  = 32'h0;
      l1.arlen   = 8'h0;
      l1.arsize  = 3'd1;
      l1.rready  = 1'b0;
      l1.awvalid = 1'b0;
      l1.awaddr  = 32'h0;
      l1.awlen   = 8'h0;
      l1.awsize  = 3'd1;
      l1.wvalid  = 1'b0;
      l1.wdata   = 64'h0;
      l1.wstrb   = '1;
      l1.wlast   = 1'b1;
      l1.bready  = 1'b0;
      case (r_state)
         RD_REQ: begin
            l1.arvalid = 1'b1;
            l1.araddr  = w_task_addr;
            l1.arlen   = 8'(TASKS_PER_SPLITTER - 1);
            l1.arsize  = 3'(LOG_TASK_WIDTH - 3);
         end
         RD_DATA:     l1.rready = child_ready;
         RD_CNT: begin
            l1.arvalid = 1'b1;
            l1.araddr  = w_cnt_addr;
         end
         RD_PTR: begin
            l1.arvalid = 1'b1;
            l1.araddr  = r_ptr_addr;
         end
         RD_CNT_WAIT, RD_PTR_WAIT: l1.rready = 1'b1;
         WR_CNT: begin
            l1.awvalid = 1'b1;
            l1.wvalid  = 1'b1;
            l1.awaddr  = w_cnt_addr;
            l1.wdata   = w_chunk_full ? 64'h0 : 64'(w_cnt_inc[15:0]);
         end
         WR_ENTRY: begin
            l1.awvalid = 1'b1;
            l1.wvalid  = 1'b1;
            l1.awaddr  = w_entry_addr;
            l1.awsize  = 3'(LOG_SPLITTER_STACK_ENTRY_WIDTH - 3);
            l1.wdata   = 64'(r_chunk[STACK_WIDTH-1:0]);
         end
         WR_PTR: begin
            l1.awvalid = 1'b1;
            l1.wvalid  = 1'b1;
            l1.awaddr  = r_ptr_addr;
            l1.wdata   = 64'(w_ptr_dec);
         end
         WR_CNT_WAIT, WR_ENTRY_WAIT, WR_PTR_WAIT: l1.bready = 1'b1;
         default: ;
      endcase
   end

   // Once the lock is taken it is held through the whole count/push sequence, even if the
   // coalescer raises its own request in the meantime.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_slot         <= '0;
         r_chunk        <= '0;
         r_beats        <= '0;
         r_cnt          <= '0;
         r_ptr          <= '0;
         r_lock         <= 1'b0;
         r_num_splits   <= '0;
         r_num_children <= '0;
         r_num_frees    <= '0;
      end else begin
         if (w_split_hs) r_num_splits <= r_num_splits + 32'd1;
         if (w_child_hs) r_num_children <= r_num_children + 32'd1;
         case (r_state)
            IDLE: if (w_split_hs) begin
               r_slot  <= splitter_task[31:16];
               r_chunk <= splitter_task[31:16] >> LOG_SPLITTERS_PER_CHUNK;
               r_state <= RD_REQ;
            end
            RD_REQ: if (l1.arready) begin
               r_beats <= '0;
               r_state <= RD_DATA;
            end
            RD_DATA: if (w_child_hs) begin
               r_beats <= r_beats + 8'd1;
               if (w_last_beat) r_state <= GRAB_LOCK;
            end
            GRAB_LOCK: if (!stack_lock_in) begin
               r_lock  <= 1'b1;
               r_state <= HOLD_LOCK;
            end
            HOLD_LOCK:   r_state <= RD_CNT;
            RD_CNT:      if (l1.arready) r_state <= RD_CNT_WAIT;
            RD_CNT_WAIT: if (l1.rvalid) begin
               r_cnt   <= l1.rdata[15:0];
               r_state <= WR_CNT;
            end
            WR_CNT:      if (w_aw_w_hs) r_state <= WR_CNT_WAIT;
            WR_CNT_WAIT: if (l1.bvalid) r_state <= w_chunk_full ? RD_PTR : RELEASE;
            RD_PTR:      if (l1.arready) r_state <= RD_PTR_WAIT;
            RD_PTR_WAIT: if (l1.rvalid) begin
               r_ptr   <= l1.rdata[15:0];
               r_state <= WR_ENTRY;
            end
            WR_ENTRY:      if (w_aw_w_hs) r_state <= WR_ENTRY_WAIT;
            WR_ENTRY_WAIT: if (l1.bvalid) r_state <= WR_PTR;
            WR_PTR:        if (w_aw_w_hs) r_state <= WR_PTR_WAIT;
            WR_PTR_WAIT:   if (l1.bvalid) begin
               r_num_frees <= r_num_frees + 32'd1;
               r_state     <= RELEASE;
            end
            RELEASE: begin
               r_lock  <= 1'b0;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Base registers hold 64-byte-aligned addresses written in units of 64 bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_start        <= 1'b0;
         r_base_tasks   <= '0;
         r_base_stack   <= '0;
         r_base_scratch <= '0;
         r_ptr_addr     <= '0;
      end else if (reg_bus.wvalid) begin
         case (reg_bus.waddr)
            REG_CORE_START:         r_start        <= reg_bus.wdata[CORE_ID];
            REG_SPILL_BASE_TASKS:   r_base_tasks   <= {reg_bus.wdata[25:0], 6'b0};
            REG_SPILL_BASE_STACK:   r_base_stack   <= {reg_bus.wdata[25:0], 6'b0};
            REG_SPILL_BASE_SCRATCH: r_base_scratch <= {reg_bus.wdata[25:0], 6'b0};
            REG_SPILL_STACK_PTR:    r_ptr_addr     <= {reg_bus.wdata[25:0], 6'b0};
            default: ;
         endcase
      end
   end

   always_comb begin
      w_reg_rdata = 32'h0;
      case (reg_bus.araddr)
         REG_CORE_NUM_DEQ:   w_reg_rdata = r_num_splits;
         REG_CORE_NUM_ENQ:   w_reg_rdata = r_num_children;
         REG_CORE_STATE:     w_reg_rdata = 32'(r_state);
         REG_CORE_NUM_FREES: w_reg_rdata = r_num_frees;
         REG_TILE_INFO:      w_reg_rdata = {16'(TILE_ID), 16'(CORE_ID)};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_rvalid <= 1'b0;
         r_reg_rdata  <= '0;
      end else begin
         r_reg_rvalid <= reg_bus.arvalid;
         if (reg_bus.arvalid) r_reg_rdata <= w_reg_rdata;
      end
   end

endmodule

// File: tb/tb_spill_splitter.sv
// Directed bench for spill_splitter: a small AXI memory model serves task beats, the scratchpad
// done counts and the free stack, while one linear initial block drives and checks each scenario.
module tb_spill_splitter;

   localparam logic [31:0] TASK_BASE  = 32'h0001_0000;
   localparam logic [31:0] STACK_BASE = 32'h0000_2000;
   localparam logic [31:0] SCR_BASE   = 32'h0000_3000;
   localparam logic [31:0] PTR_ADDR   = 32'h0000_4000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        splitterValid;
   logic        splitterReady;
   logic [63:0] splitterTask;
   logic        childValid;
   logic        childReadyBase;
   logic        toggleMode;
   logic        togglePhase = 1'b0;
   logic        childReady;
   logic [63:0] childTask;
   logic        lockOut;
   logic        lockIn;

   axi_bus_t l1();
   reg_bus_t regBus();

   spill_splitter dut (
      .clk            (clk),
      .rst            (rst),
      .l1             (l1),
      .reg_bus        (regBus),
      .splitter_valid (splitterValid),
      .splitter_ready (splitterReady),
      .splitter_task  (splitterTask),
      .child_valid    (childValid),
      .child_ready    (childReady),
      .child_task     (childTask),
      .stack_lock_out (lockOut),
      .stack_lock_in  (lockIn)
   );

   assign childReady = toggleMode ? togglePhase : childReadyBase;

   // Memory model state
   logic        rdActive = 1'b0;
   logic [31:0] rdAddr = '0;
   logic [7:0]  rdLen = '0;
   logic [7:0]  rdBeat = '0;
   logic [2:0]  rdSize = '0;
   logic        bPending = 1'b0;
   logic [15:0] scratchMem [0:15];
   logic [15:0] stackMem [0:31];
   logic [15:0] stackPtr = '0;
   logic [31:0] lastTaskAraddr = '0;
   logic [63:0] rdDataModel;
   int          earlyLast = 0;
   logic        cmdValid = 1'b0;
   logic [3:0]  cmdIdx = '0;
   logic [15:0] cmdCnt = '0;
   logic [15:0] cmdPtr = '0;
   int          protoErr = 0;
   int          mirrorErr = 0;
   logic [63:0] childQ [$];
   logic [31:0] wrAddrQ [$];
   logic [63:0] wrDataQ [$];

   int numAsserts = 0;
   int numFails   = 0;

   assign l1.arready = !rdActive;
   assign l1.rvalid  = rdActive;
   assign l1.rlast   = rdActive && ((rdBeat == rdLen) ||
                       (earlyLast != 0 && rdSize == 3'd3 && int'(rdBeat) == earlyLast - 1));
   assign l1.awready = !bPending;
   assign l1.wready  = !bPending;
   assign l1.bvalid  = bPending;
   assign l1.rdata   = rdDataModel;

   always_comb begin
      rdDataModel = 64'h0;
      if (rdSize == 3'd3)
         rdDataModel = {32'hC0DE_0000, rdAddr + (32'(rdBeat) << 3)};
      else if (rdAddr == PTR_ADDR)
         rdDataModel = {48'h0, stackPtr};
      else
         rdDataModel = {48'h0, scratchMem[4'((rdAddr - SCR_BASE) >> 1)]};
   end

   // AXI slave: one outstanding read burst, single-beat writes answered one cycle later.
   always @(posedge clk) begin
      togglePhase <= ~togglePhase;
      if (cmdValid) begin
         scratchMem[cmdIdx] <= cmdCnt;
         stackPtr           <= cmdPtr;
      end
      if (rst) begin
         rdActive <= 1'b0;
         bPending <= 1'b0;
      end else begin
         if (l1.arvalid && l1.arready) begin
            rdActive <= 1'b1;
            rdAddr   <= l1.araddr;
            rdLen    <= l1.arlen;
            rdSize   <= l1.arsize;
            rdBeat   <= '0;
            if (l1.arsize == 3'd3) lastTaskAraddr <= l1.araddr;
         end
         if (l1.rvalid && l1.rready) begin
            rdBeat <= rdBeat + 8'd1;
            if (l1.rlast) rdActive <= 1'b0;
         end
         if (l1.awvalid && l1.awready && l1.wvalid && l1.wready) begin
            bPending <= 1'b1;
            wrAddrQ.push_back(l1.awaddr);
            wrDataQ.push_back(l1.wdata);
            if (l1.awaddr == PTR_ADDR)
               stackPtr <= l1.wdata[15:0];
            else if (l1.awaddr >= SCR_BASE && l1.awaddr < SCR_BASE + 32'h20)
               scratchMem[4'((l1.awaddr - SCR_BASE) >> 1)] <= l1.wdata[15:0];
            else if (l1.awaddr >= STACK_BASE && l1.awaddr < STACK_BASE + 32'h40)
               stackMem[5'((l1.awaddr - STACK_BASE) >> 1)] <= l1.wdata[15:0];
         end
         if (l1.bvalid && l1.bready) bPending <= 1'b0;
         if (childValid && childReady) childQ.push_back(childTask);
         if ((l1.awvalid !== l1.wvalid) ||
             (l1.awvalid && (l1.awlen != 8'h0 || l1.wlast !== 1'b1 || l1.wstrb !== 8'hFF)))
            protoErr <= protoErr + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && rdActive && rdSize == 3'd3) begin
         if (l1.rready !== childReady || childValid !== l1.rvalid || childTask !== l1.rdata)
            mirrorErr <= mirrorErr + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numAsserts++;
      assert (observed === expected)
      else begin
         numFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic regWrite(input logic [7:0] addr, input logic [31:0] data);
      regBus.wvalid = 1'b1;
      regBus.waddr  = addr;
      regBus.wdata  = data;
      tick();
      regBus.wvalid = 1'b0;
   endtask

   task automatic regRead(input logic [7:0] addr, output logic [31:0] data, output logic vld);
      regBus.arvalid = 1'b1;
      regBus.araddr  = addr;
      tick();
      regBus.arvalid = 1'b0;
      vld  = regBus.rvalid;
      data = regBus.rdata;
   endtask

   task automatic configure();
      regWrite(8'h04, TASK_BASE >> 6);
      regWrite(8'h08, STACK_BASE >> 6);
      regWrite(8'h0C, SCR_BASE >> 6);
      regWrite(8'h10, PTR_ADDR >> 6);
      regWrite(8'h00, 32'h0000_0008);
   endtask

   task automatic preload(input logic [3:0] idx, input logic [15:0] cnt, input logic [15:0] ptr);
      cmdIdx   = idx;
      cmdCnt   = cnt;
      cmdPtr   = ptr;
      cmdValid = 1'b1;
      tick();
      cmdValid = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [15:0] slot);
      logic hs;
      hs = 1'b0;
      splitterValid = 1'b1;
      splitterTask  = {32'h0, slot, 16'h0};
      for (int n = 0; n < 100 && !hs; n++) begin
         if (splitterReady) hs = 1'b1;
         tick();
      end
      splitterValid = 1'b0;
      checkOutput({tag, "_handshake"}, 64'(hs), 64'd1);
   endtask

   task automatic waitDone(input string tag);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 1000 && !ok; n++) begin
         if (splitterReady) ok = 1'b1;
         else tick();
      end
      checkOutput({tag, "_done"}, 64'(ok), 64'd1);
   endtask

   task automatic checkChildren(input string tag, input int base, input int n, input logic [31:0] addr);
      checkOutput({tag, "_count"}, 64'(childQ.size() - base), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (base + i < childQ.size())
            checkOutput($sformatf("%s_child%0d", tag, i), childQ[base + i],
                        {32'hC0DE_0000, addr + 32'(i * 8)});
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          base, wbase, cnt;
      logic [31:0] rd;
      logic        vld;

      rst = 1'b1;
      splitterValid = 1'b0;
      splitterTask = '0;
      childReadyBase = 1'b1;
      toggleMode = 1'b0;
      lockIn = 1'b0;
      regBus.wvalid = 1'b0;
      regBus.waddr = '0;
      regBus.wdata = '0;
      regBus.arvalid = 1'b0;
      regBus.araddr = '0;
      repeat (3) tick();
      checkOutput("rst_ready", 64'(splitterReady), 64'd0);
      checkOutput("rst_lock", 64'(lockOut), 64'd0);
      checkOutput("rst_child_valid", 64'(childValid), 64'd0);
      checkOutput("rst_arvalid", 64'(l1.arvalid), 64'd0);
      checkOutput("rst_awvalid", 64'(l1.awvalid), 64'd0);
      checkOutput("rst_reg_rvalid", 64'(regBus.rvalid), 64'd0);
      rst = 1'b0;
      tick();
      regRead(8'h1C, rd, vld);
      checkOutput("rst_reg_rvalid_after_read", 64'(vld), 64'd1);
      checkOutput("rst_state", 64'(rd), 64'd0);
      regRead(8'h24, rd, vld);
      checkOutput("tile_info", 64'(rd), 64'h0000_0003);
      configure();

      // Slot 5, chunk 1, done count 0 -> 1
      preload(4'd1, 16'd0, 16'd0);
      base = childQ.size(); wbase = wrAddrQ.size();
      applyStimulus("t1", 16'h0005);
      waitDone("t1");
      checkOutput("t1_araddr", 64'(lastTaskAraddr), 64'h0001_0A00);
      checkChildren("t1", base, 8, 32'h0001_0A00);
      checkOutput("t1_writes", 64'(wrAddrQ.size() - wbase), 64'd1);
      if (wrAddrQ.size() > wbase) begin
         checkOutput("t1_cnt_addr", 64'(wrAddrQ[wbase]), 64'h3002);
         checkOutput("t1_cnt_data", wrDataQ[wbase], 64'd1);
      end
      checkOutput("t1_lock", 64'(lockOut), 64'd0);

      // Same slot with child_ready toggling; count 1 -> 2
      base = childQ.size();
      toggleMode = 1'b1;
      applyStimulus("t2", 16'h0005);
      waitDone("t2");
      toggleMode = 1'b0;
      checkChildren("t2", base, 8, 32'h0001_0A00);
      checkOutput("t2_scratch", 64'(scratchMem[1]), 64'd2);
      checkOutput("t2_mirror_errors", 64'(mirrorErr), 64'd0);

      // Last splitter of chunk 3 frees it: stack_ptr 10 -> 9, entry[9] = 3
      preload(4'd3, 16'd3, 16'd10);
      wbase = wrAddrQ.size();
      applyStimulus("t3", 16'h000C);
      waitDone("t3");
      checkOutput("t3_writes", 64'(wrAddrQ.size() - wbase), 64'd3);
      if (wrAddrQ.size() >= wbase + 3) begin
         checkOutput("t3_cnt_addr", 64'(wrAddrQ[wbase]), 64'h3006);
         checkOutput("t3_cnt_data", wrDataQ[wbase], 64'd0);
         checkOutput("t3_entry_addr", 64'(wrAddrQ[wbase + 1]), 64'h2012);
         checkOutput("t3_entry_data", wrDataQ[wbase + 1], 64'd3);
         checkOutput("t3_ptr_addr", 64'(wrAddrQ[wbase + 2]), 64'h4000);
         checkOutput("t3_ptr_data", wrDataQ[wbase + 2], 64'd9);
      end
      checkOutput("t3_stack_entry", 64'(stackMem[9]), 64'd3);
      checkOutput("t3_stack_ptr", 64'(stackPtr), 64'd9);

      // Burst terminated early by rlast after 4 beats
      preload(4'd1, 16'd0, 16'd9);
      base = childQ.size();
      earlyLast = 4;
      applyStimulus("t4", 16'h0006);
      waitDone("t4");
      earlyLast = 0;
      checkChildren("t4", base, 4, 32'h0001_0C00);
      checkOutput("t4_scratch", 64'(scratchMem[1]), 64'd1);

      // Coalescer holds the lock for 20 cycles, then both request in the same cycle
      preload(4'd0, 16'd0, 16'd9);
      base = childQ.size();
      lockIn = 1'b1;
      applyStimulus("t5", 16'h0000);
      for (int n = 0; n < 200 && childQ.size() - base < 8; n++) tick();
      checkChildren("t5", base, 8, 32'h0001_0000);
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (lockOut !== 1'b0) cnt++;
      end
      checkOutput("t5_lock_held_off", 64'(cnt), 64'd0);
      lockIn = 1'b0;
      checkOutput("t5_lock_before_edge", 64'(lockOut), 64'd0);
      tick();
      checkOutput("t5_lock_taken", 64'(lockOut), 64'd1);
      lockIn = 1'b1;
      waitDone("t5");
      checkOutput("t5_scratch", 64'(scratchMem[0]), 64'd1);
      checkOutput("t5_lock_released", 64'(lockOut), 64'd0);
      lockIn = 1'b0;

      regRead(8'h14, rd, vld);
      checkOutput("num_splits", 64'(rd), 64'd5);
      regRead(8'h18, rd, vld);
      checkOutput("num_children", 64'(rd), 64'd36);
      regRead(8'h20, rd, vld);
      checkOutput("num_frees", 64'(rd), 64'd1);
      checkOutput("proto_errors", 64'(protoErr), 64'd0);

      // start=0 blocks new handshakes
      regWrite(8'h00, 32'h0000_0000);
      splitterValid = 1'b1;
      cnt = 0;
      for (int n = 0; n < 5; n++) begin
         if (splitterReady) cnt++;
         tick();
      end
      splitterValid = 1'b0;
      checkOutput("stopped_ready", 64'(cnt), 64'd0);

      // Reset during beat 3 of a burst abandons the operation
      regWrite(8'h00, 32'h0000_0008);
      preload(4'd1, 16'd2, 16'd9);
      base = childQ.size();
      applyStimulus("t6", 16'h0007);
      for (int n = 0; n < 200 && childQ.size() - base < 3; n++) tick();
      rst = 1'b1;
      tick();
      checkOutput("t6_lock_in_rst", 64'(lockOut), 64'd0);
      checkOutput("t6_child_valid_in_rst", 64'(childValid), 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("t6_children_taken", 64'(childQ.size() - base), 64'd3);
      regRead(8'h1C, rd, vld);
      checkOutput("t6_state", 64'(rd), 64'd0);
      regRead(8'h18, rd, vld);
      checkOutput("t6_num_children", 64'(rd), 64'd0);
      checkOutput("t6_ready_after_rst", 64'(splitterReady), 64'd0);

      configure();
      base = childQ.size();
      applyStimulus("t7", 16'h0005);
      waitDone("t7");
      checkChildren("t7", base, 8, 32'h0001_0A00);
      checkOutput("t7_scratch", 64'(scratchMem[1]), 64'd3);
      regRead(8'h14, rd, vld);
      checkOutput("t7_num_splits", 64'(rd), 64'd1);
      checkOutput("t7_mirror_errors", 64'(mirrorErr), 64'd0);
      checkOutput("t7_proto_errors", 64'(protoErr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
      $finish;
   end

endmodule
